// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the BCD sweep sequencer.
// PAUSED exists only when SWEEP_PAUSE_EN is defined.
package counter_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UP       = 3'd1,
    S_DWELL_HI = 3'd2,
    S_DOWN     = 3'd3,
    S_DWELL_LO = 3'd4,
    S_DONE     = 3'd5
`ifdef SWEEP_PAUSE_EN
    ,S_PAUSED  = 3'd6
`endif
  } state_t;

  localparam logic [1:0] SPEED0 = 2'd0;
  localparam logic [1:0] SPEED1 = 2'd1;
  localparam logic [1:0] SPEED2 = 2'd2;

  localparam logic [3:0] GLYPH_UP   = 4'd10;
  localparam logic [3:0] GLYPH_DOWN = 4'd11;

  localparam logic [7:0] BCD_MAX = 8'h99;

  function automatic logic [3:0] clamp_bcd(
    input logic [3:0] d
  );
    return (d > BCD_MAX[3:0]) ? BCD_MAX[3:0] : d;
  endfunction

endpackage

// File: rtl/sweep_ctrl_if.sv
// Control/status bundle between the sweep sequencer
// and the button logic plus BCD datapath.
interface sweep_ctrl_if;
  logic       start_p;
  logic       stop_p;
  logic       pause_p;
  logic [1:0] speed;
  logic [3:0] target1;
  logic [3:0] target0;
  logic [3:0] reps;
  logic [3:0] val1;
  logic [3:0] val0;
  logic       inc_p;
  logic       dec_p;
  logic       busy;
  logic       done;
  logic [3:0] dir_code;
  logic [3:0] rep_left;

  modport master (
    output start_p, stop_p, pause_p, speed,
    output target1, target0, reps, val1, val0,
    input  inc_p, dec_p, busy, done,
    input  dir_code, rep_left
  );

  modport slave (
    input  start_p, stop_p, pause_p, speed,
    input  target1, target0, reps, val1, val0,
    output inc_p, dec_p, busy, done,
    output dir_code, rep_left
  );
endinterface

// File: rtl/sweep_ctrl_step_timer.sv
// Divider with clear/freeze; ticks once the count reaches
// i_lim, so a lowered limit fires on the next edge.
module step_timer
  import counter_ctrl_pkg::*;
(
  input  logic             clk_p,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_frz,
  input  logic [CNT_W-1:0] i_lim,
  output logic             o_tick
);
  logic [CNT_W-1:0] r_cnt;

  assign o_tick = !i_frz && (r_cnt >= i_lim);

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (!i_frz) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sweep_ctrl.sv
// Up/down sweep sequencer issuing BCD step strobes.
// Optional pause/resume via SWEEP_PAUSE_EN.
module sweep_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int STEP_DIV0 = 5000,
  parameter int STEP_DIV1 = 2500,
  parameter int STEP_DIV2 = 1250,
  parameter int DWELL     = 5000
) (
  input  logic        clk_p,
  input  logic        rst,
  sweep_ctrl_if.slave bus
);
  state_t           r_st;
  state_t           w_nxt;
  logic [7:0]       r_tgt;
  logic [7:0]       w_tgt_in;
  logic [7:0]       w_val;
  logic [3:0]       r_rep;
  logic [3:0]       w_rep;
  logic             r_inc;
  logic             r_dec;
  logic             w_inc;
  logic             w_dec;
  logic             w_ld;
  logic             w_stick;
  logic             w_dtick;
  logic             w_sclr;
  logic             w_dclr;
  logic             w_hold;
  logic             w_frz;
  logic             w_dn;
  logic [CNT_W-1:0] w_slim;
  logic [CNT_W-1:0] w_dlim;

  assign w_val    = {bus.val1, bus.val0};
  assign w_tgt_in = {clamp_bcd(bus.target1),
                     clamp_bcd(bus.target0)};
  assign w_ld     = (r_st == S_IDLE) && bus.start_p
                    && !bus.stop_p;
  assign w_dlim   = CNT_W'(DWELL - 1);

`ifdef SWEEP_PAUSE_EN
  state_t r_sav;
  logic   w_pause;

  assign w_hold  = (r_st == S_PAUSED);
  assign w_pause = bus.pause_p &&
                   (r_st == S_UP || r_st == S_DOWN ||
                    r_st == S_DWELL_HI ||
                    r_st == S_DWELL_LO);
  // Freezing on the pause cycle keeps a coincident tick pending.
  assign w_frz   = w_hold || w_pause;

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      r_sav <= S_IDLE;
    end else if (w_nxt == S_PAUSED && !w_hold) begin
      r_sav <= r_st;
    end
  end
`else
  logic w_unused;
  assign w_unused = bus.pause_p;
  assign w_hold   = 1'b0;
  assign w_frz    = 1'b0;
`endif

  always_comb begin
    w_slim = CNT_W'(STEP_DIV2 - 1);
    unique case (1'b1)
      bus.speed == SPEED0: w_slim = CNT_W'(STEP_DIV0 - 1);
      bus.speed == SPEED1: w_slim = CNT_W'(STEP_DIV1 - 1);
      default:             w_slim = CNT_W'(STEP_DIV2 - 1);
    endcase
  end

  assign w_sclr = !(r_st == S_UP || r_st == S_DOWN
                    || w_hold);
  assign w_dclr = !(r_st == S_DWELL_HI ||
                    r_st == S_DWELL_LO || w_hold);

  step_timer u_step (
    .clk_p  (clk_p),
    .rst    (rst),
    .i_clr  (w_sclr),
    .i_frz  (w_frz),
    .i_lim  (w_slim),
    .o_tick (w_stick)
  );

  step_timer u_dwell (
    .clk_p  (clk_p),
    .rst    (rst),
    .i_clr  (w_dclr),
    .i_frz  (w_frz),
    .i_lim  (w_dlim),
    .o_tick (w_dtick)
  );

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      r_st  <= S_IDLE;
      r_tgt <= '0;
      r_rep <= '0;
      r_inc <= 1'b0;
      r_dec <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_rep <= w_rep;
      r_inc <= w_inc;
      r_dec <= w_dec;
      if (w_ld) r_tgt <= w_tgt_in;
    end
  end

  always_comb begin
    w_nxt = r_st;
    w_rep = r_rep;
    w_inc = 1'b0;
    w_dec = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (bus.start_p) begin
          if (w_tgt_in == 8'h00) begin
            w_nxt = S_DONE;
            w_rep = '0;
          end else begin
            w_nxt = S_UP;
            w_rep = bus.reps;
          end
        end
      end
      S_UP: begin
        if (w_stick) begin
          if (w_val >= r_tgt) w_nxt = S_DWELL_HI;
          else                w_inc = 1'b1;
        end
      end
      S_DWELL_HI: begin
        if (w_dtick) w_nxt = S_DOWN;
      end
      S_DOWN: begin
        if (w_stick) begin
          if (w_val == 8'h00) w_nxt = S_DWELL_LO;
          else                w_dec = 1'b1;
        end
      end
      S_DWELL_LO: begin
        if (w_dtick) begin
          // rep_left of 0 means run forever
          if (r_rep == 4'd0) begin
            w_nxt = S_UP;
          end else if (r_rep == 4'd1) begin
            w_nxt = S_DONE;
            w_rep = '0;
          end else begin
            w_nxt = S_UP;
            w_rep = r_rep - 4'd1;
          end
        end
      end
      S_DONE: begin
        w_nxt = S_IDLE;
        w_rep = '0;
      end
`ifdef SWEEP_PAUSE_EN
      S_PAUSED: begin
        if (bus.pause_p) w_nxt = r_sav;
      end
`endif
      default: w_nxt = S_IDLE;
    endcase
`ifdef SWEEP_PAUSE_EN
    if (w_pause) begin
      w_nxt = S_PAUSED;
      w_inc = 1'b0;
      w_dec = 1'b0;
    end
`endif
    if (bus.stop_p) begin
      w_nxt = S_IDLE;
      w_rep = r_rep;
      w_inc = 1'b0;
      w_dec = 1'b0;
    end
  end

  always_comb begin
    bus.busy = (r_st != S_IDLE);
    bus.done = (r_st == S_DONE);
    w_dn     = (r_st == S_DOWN) || (r_st == S_DWELL_HI);
`ifdef SWEEP_PAUSE_EN
    if (w_hold) begin
      w_dn = (r_sav == S_DOWN) || (r_sav == S_DWELL_HI);
    end
`endif
    bus.dir_code = w_dn ? GLYPH_DOWN : GLYPH_UP;
  end

  assign bus.inc_p    = r_inc;
  assign bus.dec_p    = r_dec;
  assign bus.rep_left = r_rep;
endmodule
